// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I/E OP, OP-IMM and BRANCH into ALU microcode and registers operands.
// Optional one-entry skid buffer enabled by defining ALU_ISSUE_SKID_EN.

`ifndef ALU_MICROCODE_ADD
`define ALU_MICROCODE_ADD  4'd0
`define ALU_MICROCODE_SUB  4'd1
`define ALU_MICROCODE_SLL  4'd2
`define ALU_MICROCODE_SLT  4'd3
`define ALU_MICROCODE_SLTU 4'd4
`define ALU_MICROCODE_XOR  4'd5
`define ALU_MICROCODE_SRL  4'd6
`define ALU_MICROCODE_SRA  4'd7
`define ALU_MICROCODE_OR   4'd8
`define ALU_MICROCODE_AND  4'd9
`define ALU_MICROCODE_BEQ  4'd10
`define ALU_MICROCODE_BNE  4'd11
`define ALU_MICROCODE_BLT  4'd12
`define ALU_MICROCODE_BGE  4'd13
`define ALU_MICROCODE_BLTU 4'd14
`define ALU_MICROCODE_BGEU 4'd15
`endif

package alu_issue_pkg;
  typedef logic [3:0] alu_microcode_t;

  typedef struct packed {
    alu_microcode_t mc;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [4:0]     rd;
    logic           is_branch;
    logic           illegal;
  } entry_t;
endpackage

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [31:0]    in_rs1,
  input  logic [31:0]    in_rs2,
  output logic           out_valid,
  input  logic           out_ready,
  output alu_microcode_t out_microcode,
  output logic [31:0]    out_a,
  output logic [31:0]    out_b,
  output logic [4:0]     out_rd,
  output logic           out_is_branch,
  output logic           out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  localparam entry_t ENTRY_RESET = '{mc: `ALU_MICROCODE_ADD, a: 32'd0, b: 32'd0,
                                     rd: 5'd0, is_branch: 1'b0, illegal: 1'b0};

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1_f, rs2_f, rd_f;
  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rd_f   = in_instr[11:7];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];

  alu_microcode_t arith_mc;
  alu_microcode_t branch_mc;
  logic           bad_enc;
  logic           bad_reg;
  entry_t         dec;

  // Shared f3 map for OP f7=0 and OP-IMM; SRA/SUB are patched in per format.
  always_comb begin
    arith_mc = `ALU_MICROCODE_ADD;
    case (f3)
      3'b000: arith_mc = `ALU_MICROCODE_ADD;
      3'b001: arith_mc = `ALU_MICROCODE_SLL;
      3'b010: arith_mc = `ALU_MICROCODE_SLT;
      3'b011: arith_mc = `ALU_MICROCODE_SLTU;
      3'b100: arith_mc = `ALU_MICROCODE_XOR;
      3'b101: arith_mc = `ALU_MICROCODE_SRL;
      3'b110: arith_mc = `ALU_MICROCODE_OR;
      default: arith_mc = `ALU_MICROCODE_AND;
    endcase
  end

  always_comb begin
    branch_mc = `ALU_MICROCODE_BEQ;
    case (f3)
      3'b000: branch_mc = `ALU_MICROCODE_BEQ;
      3'b001: branch_mc = `ALU_MICROCODE_BNE;
      3'b100: branch_mc = `ALU_MICROCODE_BLT;
      3'b101: branch_mc = `ALU_MICROCODE_BGE;
      3'b110: branch_mc = `ALU_MICROCODE_BLTU;
      default: branch_mc = `ALU_MICROCODE_BGEU;
    endcase
  end

  always_comb begin
    dec           = ENTRY_RESET;
    dec.a         = in_rs1;
    dec.b         = in_rs2;
    dec.rd        = rd_f;
    bad_enc       = 1'b0;
    bad_reg       = 1'b0;
    case (opcode)
      7'b0010011: begin
        dec.b  = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.mc = arith_mc;
        if (f3 == 3'b001 && f7 != 7'b0000000) bad_enc = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec.mc  = `ALU_MICROCODE_SRA;
          else if (f7 != 7'b0000000) bad_enc = 1'b1;
        end
        bad_reg = RV32E && (rs1_f[4] || rd_f[4]);
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          dec.mc = arith_mc;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.mc = `ALU_MICROCODE_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.mc = `ALU_MICROCODE_SRA;
        end else begin
          bad_enc = 1'b1;
        end
        bad_reg = RV32E && (rs1_f[4] || rs2_f[4] || rd_f[4]);
      end
      7'b1100011: begin
        dec.mc        = branch_mc;
        dec.rd        = 5'd0;
        dec.is_branch = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) bad_enc = 1'b1;
        bad_reg = RV32E && (rs1_f[4] || rs2_f[4]);
      end
      default: bad_enc = 1'b1;
    endcase
    if (bad_enc || bad_reg) begin
      dec         = ENTRY_RESET;
      dec.illegal = 1'b1;
    end
  end

  entry_t main_q;
  logic   main_valid;
  logic   accept;
  logic   out_fire;

  assign accept   = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_full;

  assign in_ready = ~skid_full;

  // Skid only fills when an accept meets a stalled main register; it drains on the next out-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= ENTRY_RESET;
      main_valid <= 1'b0;
      skid_q     <= ENTRY_RESET;
      skid_full  <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (skid_full) begin
      if (out_fire) begin
        main_q    <= skid_q;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || out_ready) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~main_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= ENTRY_RESET;
      main_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (accept) begin
      main_q     <= dec;
      main_valid <= 1'b1;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign out_valid     = main_valid;
  assign out_microcode = main_q.mc;
  assign out_a         = main_q.a;
  assign out_b         = main_q.b;
  assign out_rd        = main_q.rd;
  assign out_is_branch = main_q.is_branch;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue; one task per scenario, inline checks, single summary line.
`timescale 1ns/1ps

module tb_alu_issue;

  localparam logic [3:0] MC_ADD = 4'd0;
  localparam logic [3:0] MC_SUB = 4'd1;
  localparam logic [3:0] MC_XOR = 4'd5;
  localparam logic [3:0] MC_SRA = 4'd7;
  localparam logic [3:0] MC_BEQ = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_rs1 = 32'd0;
  logic [31:0] in_rs2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_microcode;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_is_branch, out_illegal;

  logic        e_in_ready, e_out_valid, e_is_branch, e_illegal;
  logic [3:0]  e_microcode;
  logic [31:0] e_a, e_b;
  logic [4:0]  e_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_microcode(out_microcode),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  alu_issue #(.RV32E(1'b1)) dut_e (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_microcode(e_microcode),
    .out_a(e_a), .out_b(e_b), .out_rd(e_rd),
    .out_is_branch(e_is_branch), .out_illegal(e_illegal)
  );

  // All tasks start and end at 1ns after a rising edge.
  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy);
    in_valid = 1'b1; in_instr = i; in_rs1 = r1; in_rs2 = r2; out_ready = ordy;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_microcode !== MC_ADD) begin errors++; $display("FAIL reset_mc got=%0d exp=%0d", out_microcode, MC_ADD); end
    checks++; if (out_a !== 32'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", out_a); end
    checks++; if (out_b !== 32'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", out_b); end
    checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", out_rd); end
    checks++; if (out_is_branch !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", out_is_branch, out_illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_decode();
    issue(32'h002081B3, 32'd5, 32'd7, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_microcode !== MC_ADD) begin errors++; $display("FAIL add_mc got=%0d exp=%0d", out_microcode, MC_ADD); end
    checks++; if (out_a !== 32'd5 || out_b !== 32'd7) begin errors++; $display("FAIL add_ab got=%h/%h exp=5/7", out_a, out_b); end
    checks++; if (out_rd !== 5'd3 || out_illegal !== 1'b0 || out_is_branch !== 1'b0) begin errors++; $display("FAIL add_rd got rd=%0d ill=%b br=%b exp 3/0/0", out_rd, out_illegal, out_is_branch); end

    issue(32'h402081B3, 32'd5, 32'd7, 1'b1);
    checks++; if (out_microcode !== MC_SUB) begin errors++; $display("FAIL sub_mc got=%0d exp=%0d", out_microcode, MC_SUB); end

    issue(32'hFFF00093, 32'd0, 32'h1234, 1'b1);
    checks++; if (out_b !== 32'hFFFFFFFF || out_rd !== 5'd1) begin errors++; $display("FAIL addi got b=%h rd=%0d exp ffffffff/1", out_b, out_rd); end
    checks++; if (out_microcode !== MC_ADD) begin errors++; $display("FAIL addi_mc got=%0d exp=%0d", out_microcode, MC_ADD); end

    issue(32'h40335293, 32'h80000000, 32'h9, 1'b1);
    checks++; if (out_microcode !== MC_SRA) begin errors++; $display("FAIL srai_mc got=%0d exp=%0d", out_microcode, MC_SRA); end
    checks++; if (out_a !== 32'h80000000 || out_b !== 32'h00000403) begin errors++; $display("FAIL srai_ab got=%h/%h exp=80000000/00000403", out_a, out_b); end
    checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL srai_rd got=%0d exp=5", out_rd); end

    issue(32'h00208063, 32'd11, 32'd22, 1'b1);
    checks++; if (out_microcode !== MC_BEQ || out_is_branch !== 1'b1 || out_rd !== 5'd0) begin errors++; $display("FAIL beq got mc=%0d br=%b rd=%0d exp %0d/1/0", out_microcode, out_is_branch, out_rd, MC_BEQ); end
    checks++; if (out_b !== 32'd22) begin errors++; $display("FAIL beq_b got=%h exp=16", out_b); end

    issue(32'h00002063, 32'hAAAA, 32'hBBBB, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got v=%b ill=%b exp 1/1", out_valid, out_illegal); end
    checks++; if (out_microcode !== MC_ADD || out_a !== 32'd0 || out_b !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL ill_fields got mc=%0d a=%h b=%h rd=%0d exp 0/0/0/0", out_microcode, out_a, out_b, out_rd); end
    checks++; if (out_is_branch !== 1'b0) begin errors++; $display("FAIL ill_branch got=%b exp=0", out_is_branch); end
    // Word with bits[1:0]=00 but otherwise an OP add.
    issue(32'h002081B0, 32'd1, 32'd2, 1'b1);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_low_bits got=%b exp=1", out_illegal); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog[3];
    logic [8:0]  exp_q[$];
    logic [74:0] snap;
    logic        snap_ok;
    int          idx;
    int          stall_acc;
    int          exp_stall_acc;
    logic [8:0]  e;
    prog[0] = 32'h002081B3; prog[1] = 32'h0020C233; prog[2] = 32'hFFF00093;
    exp_q.push_back({MC_ADD, 5'd3});
    exp_q.push_back({MC_XOR, 5'd4});
    exp_q.push_back({MC_ADD, 5'd1});
`ifdef ALU_ISSUE_SKID_EN
    exp_stall_acc = 2;
`else
    exp_stall_acc = 1;
`endif
    do_reset();
    idx = 0; stall_acc = 0; snap_ok = 1'b0; snap = '0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      in_instr  = (idx < 3) ? prog[idx] : 32'd0;
      in_rs1    = 32'd5; in_rs2 = 32'd7;
      @(negedge clk);
      if (snap_ok && out_valid) begin
        checks++;
        if ({out_microcode, out_a, out_b, out_rd, out_is_branch, out_illegal} !== snap) begin
          errors++; $display("FAIL stall_stable cycle=%0d got=%h exp=%h", c, {out_microcode, out_a, out_b, out_rd, out_is_branch, out_illegal}, snap);
        end
      end
      if (c == 3) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got mc=%0d rd=%0d exp none", out_microcode, out_rd);
        end else begin
          e = exp_q.pop_front();
          if ({out_microcode, out_rd} !== e) begin
            errors++; $display("FAIL b2b_order got=%h exp=%h", {out_microcode, out_rd}, e);
          end
        end
      end
      snap_ok = out_valid && !out_ready;
      snap    = {out_microcode, out_a, out_b, out_rd, out_is_branch, out_illegal};
      if (in_valid && in_ready) begin
        idx++;
        if (c < 4) stall_acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (stall_acc != exp_stall_acc) begin errors++; $display("FAIL stall_accepts got=%0d exp=%0d", stall_acc, exp_stall_acc); end
    checks++; if (idx != 3 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count got accepted=%0d left=%0d exp 3/0", idx, exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    logic exp_rdy;
`ifdef ALU_ISSUE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    do_reset();
    issue(32'h002081B3, 32'd5, 32'd7, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0020C233;
    #1;
    checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL flush_in_ready got=%b exp=%b", in_ready, exp_rdy); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(32'h002081B3, 32'd5, 32'd7, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset got=%b exp=0", out_valid); end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_rv32e();
    do_reset();
    issue(32'h002088B3, 32'd1, 32'd2, 1'b1);
    checks++; if (e_out_valid !== 1'b1 || e_illegal !== 1'b1) begin errors++; $display("FAIL rv32e_illegal got v=%b ill=%b exp 1/1", e_out_valid, e_illegal); end
    checks++; if (e_rd !== 5'd0 || e_a !== 32'd0) begin errors++; $display("FAIL rv32e_fields got rd=%0d a=%h exp 0/0", e_rd, e_a); end
    checks++; if (out_illegal !== 1'b0 || out_rd !== 5'd17) begin errors++; $display("FAIL rv32i_x17 got ill=%b rd=%0d exp 0/17", out_illegal, out_rd); end
    // OP-IMM ignores the rs2 field position, so bit 24 set must stay legal under RV32E.
    issue(32'h01008093, 32'd1, 32'd2, 1'b1);
    checks++; if (e_illegal !== 1'b0 || e_b !== 32'h10) begin errors++; $display("FAIL rv32e_opimm got ill=%b b=%h exp 0/10", e_illegal, e_b); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_rv32e();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
